score_glyph_arbiter: RTL and testbench

Shares the single 16-row × 8-pixel digit glyph ROM (160 entries, 1-cycle registered-address latency) between the two score renderers: left and right player. Each renderer requests one glyph row (digit, row) with a req/gnt handshake. The arbiter grants round-robin, drives the ROM address, waits out the ROM latency, and returns the 8-bit row with a one-cycle valid strobe to the winning requester. It sits between the score renderers and the digit ROM in the pixel-clock domain.

---
 rtl/score_glyph_arbiter.sv | 111 +++++++++++
 tb/tb_score_glyph_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_glyph_arbiter.sv
// Round-robin arbiter that shares one digit glyph ROM between the left and right score renderers.
// One fetch in flight: grant -> ROM address latency -> capture, then a one-cycle valid to the owner.
module score_glyph_arbiter (
    input  logic       P_CLK,
    input  logic       P_RST_N,
    input  logic       req_l,
    input  logic [3:0] digit_l,
    input  logic [3:0] row_l,
    input  logic       req_r,
    input  logic [3:0] digit_r,
    input  logic [3:0] row_r,
    output logic       gnt_l,
    output logic       gnt_r,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] row_data,
    output logic       valid_l,
    output logic       valid_r,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROMLAT  = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       gnt_l_q, gnt_l_d;
    logic       gnt_r_q, gnt_r_d;
    logic [7:0] rom_addr_q, rom_addr_d;
    logic [7:0] row_data_q, row_data_d;
    logic       valid_l_q, valid_l_d;
    logic       valid_r_q, valid_r_d;
    // owner and last_grant: 1 = right renderer, 0 = left renderer.
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic       pick_r;

    always_comb begin
        state_d      = state_q;
        gnt_l_d      = 1'b0;
        gnt_r_d      = 1'b0;
        rom_addr_d   = rom_addr_q;
        row_data_d   = row_data_q;
        valid_l_d    = 1'b0;
        valid_r_d    = 1'b0;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        // On contention the side not served last time wins.
        pick_r       = (req_l && req_r) ? ~last_grant_q : req_r;

        case (state_q)
            IDLE: begin
                if (req_l || req_r) begin
                    owner_d    = pick_r;
                    rom_addr_d = pick_r ? {digit_r, row_r} : {digit_l, row_l};
                    gnt_l_d    = ~pick_r;
                    gnt_r_d    = pick_r;
                    state_d    = ROMLAT;
                end
            end
            ROMLAT: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                row_data_d   = rom_data;
                valid_l_d    = ~owner_q;
                valid_r_d    = owner_q;
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge P_CLK or negedge P_RST_N) begin
        if (!P_RST_N) begin
            state_q      <= IDLE;
            gnt_l_q      <= 1'b0;
            gnt_r_q      <= 1'b0;
            rom_addr_q   <= 8'h00;
            row_data_q   <= 8'h00;
            valid_l_q    <= 1'b0;
            valid_r_q    <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            gnt_l_q      <= gnt_l_d;
            gnt_r_q      <= gnt_r_d;
            rom_addr_q   <= rom_addr_d;
            row_data_q   <= row_data_d;
            valid_l_q    <= valid_l_d;
            valid_r_q    <= valid_r_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt_l    = gnt_l_q;
    assign gnt_r    = gnt_r_q;
    assign rom_addr = rom_addr_q;
    assign row_data = row_data_q;
    assign valid_l  = valid_l_q;
    assign valid_r  = valid_r_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_score_glyph_arbiter.sv
// Bench for score_glyph_arbiter: behavioural ROM, directed scenarios, then random request traffic
// compared every cycle against a transaction-level schedule model.
module tb_score_glyph_arbiter;

    logic       P_CLK = 1'b0;
    logic       P_RST_N = 1'b0;
    logic       req_l, req_r;
    logic [3:0] digit_l, row_l, digit_r, row_r;
    logic       gnt_l, gnt_r, valid_l, valid_r, busy;
    logic [7:0] rom_addr, row_data;
    logic [7:0] rom_data = 8'h00;

    int total = 0;
    int bad   = 0;

    score_glyph_arbiter dut (
        .P_CLK    (P_CLK),
        .P_RST_N  (P_RST_N),
        .req_l    (req_l),
        .digit_l  (digit_l),
        .row_l    (row_l),
        .req_r    (req_r),
        .digit_r  (digit_r),
        .row_r    (row_r),
        .gnt_l    (gnt_l),
        .gnt_r    (gnt_r),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .row_data (row_data),
        .valid_l  (valid_l),
        .valid_r  (valid_r),
        .busy     (busy)
    );

    always #5 P_CLK = ~P_CLK;

    // Glyph contents: 12 drawn rows per digit, rows 12-15 and digits 10-15 blank.
    function automatic logic [7:0] glyph(input logic [7:0] addr);
        logic [95:0] font;
        int r;
        r = int'(addr[3:0]);
        case (addr[7:4])
            4'd0: font = 96'h00_7C_C6_C6_C6_CE_DE_F6_E6_C6_7C_00;
            4'd1: font = 96'h00_18_38_78_18_18_18_18_18_18_18_7E;
            4'd2: font = 96'h00_7C_C6_06_0C_18_30_60_C0_C6_FE_00;
            4'd3: font = 96'h00_7C_C6_06_06_06_3C_06_06_C6_7C_00;
            4'd4: font = 96'h00_0C_1C_3C_6C_CC_FE_0C_0C_0C_1E_00;
            4'd5: font = 96'h00_FE_C0_C0_FC_06_06_06_06_C6_7C_00;
            4'd6: font = 96'h00_38_60_C0_FC_C6_C6_C6_C6_C6_7C_00;
            4'd7: font = 96'h00_FE_C6_06_0C_18_30_30_30_30_30_00;
            4'd8: font = 96'h00_38_7C_C6_C6_7C_C6_C6_C6_C6_7C_00;
            4'd9: font = 96'h00_7C_C6_C6_C6_7E_06_06_06_0C_78_00;
            default: font = '0;
        endcase
        if (r > 11) return 8'h00;
        return font[95 - 8*r -: 8];
    endfunction

    always @(posedge P_CLK) rom_data <= glyph(rom_addr);

    // Reference model: schedule of edges at which things are due.
    int         cyc_n = 0;
    int         free_at, busy_until, due_at;
    bit         pend, pend_r, last_r;
    logic [7:0] pend_addr;
    logic       e_gnt_l, e_gnt_r, e_vl, e_vr, e_busy;
    logic [7:0] e_addr, e_row;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_at = 0; busy_until = 0; due_at = 0;
        pend = 0; pend_r = 0; last_r = 1;
        e_gnt_l = 0; e_gnt_r = 0; e_vl = 0; e_vr = 0; e_busy = 0;
        e_addr = 8'h00; e_row = 8'h00;
    endtask

    task automatic model_edge();
        bit win_r;
        cyc_n++;
        e_gnt_l = 0; e_gnt_r = 0; e_vl = 0; e_vr = 0;
        if (pend && cyc_n == due_at) begin
            e_row = glyph(pend_addr);
            if (pend_r) e_vr = 1; else e_vl = 1;
            last_r = pend_r;
            pend = 0;
        end
        if (cyc_n >= free_at && (req_l || req_r)) begin
            win_r     = (req_l && req_r) ? !last_r : req_r;
            pend      = 1;
            pend_r    = win_r;
            pend_addr = win_r ? {digit_r, row_r} : {digit_l, row_l};
            e_addr    = pend_addr;
            e_gnt_l   = !win_r;
            e_gnt_r   = win_r;
            due_at    = cyc_n + 2;
            free_at   = cyc_n + 3;
            busy_until = cyc_n + 2;
        end
        e_busy = (cyc_n < busy_until);
    endtask

    task automatic compare_all();
        check_eq("gnt_l", gnt_l, e_gnt_l);
        check_eq("gnt_r", gnt_r, e_gnt_r);
        check_eq("valid_l", valid_l, e_vl);
        check_eq("valid_r", valid_r, e_vr);
        check_eq("rom_addr", rom_addr, e_addr);
        check_eq("row_data", row_data, e_row);
        check_eq("busy", busy, e_busy);
    endtask

    task automatic tick();
        @(posedge P_CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    // One cycle with requesters that drop req on their grant.
    task automatic cycle();
        tick();
        if (gnt_l) req_l = 0;
        if (gnt_r) req_r = 0;
    endtask

    task automatic do_reset(input int cycles);
        P_RST_N = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (cycles) @(posedge P_CLK);
        #1;
        compare_all();
        P_RST_N = 1'b1;
    endtask

    initial begin
        req_l = 1; digit_l = 4'd3; row_l = 4'd6;
        req_r = 0; digit_r = 4'd0; row_r = 4'd0;
        model_reset();

        // Reset held with a pending left request, then single left fetch.
        do_reset(3);
        cycle();
        check_eq("t1_gnt_l", gnt_l, 8'd1);
        check_eq("t1_addr", rom_addr, 8'h36);
        cycle();
        cycle();
        check_eq("t1_valid_l", valid_l, 8'd1);
        check_eq("t1_row", row_data, 8'h3C);
        check_eq("t1_valid_r", valid_r, 8'd0);
        cycle();

        // Simultaneous requests from reset: left first, then right, then alternation.
        req_l = 1; digit_l = 4'd8; row_l = 4'd2;
        req_r = 1; digit_r = 4'd1; row_r = 4'd11;
        do_reset(2);
        cycle();
        check_eq("sim_gnt_l", gnt_l, 8'd1);
        check_eq("sim_gnt_r0", gnt_r, 8'd0);
        cycle();
        cycle();
        check_eq("sim_row_l", row_data, 8'h7C);
        check_eq("sim_valid_l", valid_l, 8'd1);
        cycle();
        check_eq("sim_gnt_r", gnt_r, 8'd1);
        cycle();
        cycle();
        check_eq("sim_row_r", row_data, 8'h7E);
        check_eq("sim_valid_r", valid_r, 8'd1);
        req_l = 1; req_r = 1;
        cycle();
        check_eq("alt_gnt_l", gnt_l, 8'd1);
        repeat (6) cycle();

        // Out-of-range digit reads as blank.
        req_r = 1; digit_r = 4'd12; row_r = 4'd4;
        cycle();
        check_eq("oor_addr", rom_addr, 8'hC4);
        cycle();
        cycle();
        check_eq("oor_row", row_data, 8'h00);
        check_eq("oor_valid_r", valid_r, 8'd1);
        cycle();

        // Inputs changed after the grant do not affect the fetch.
        req_l = 1; digit_l = 4'd0; row_l = 4'd5;
        cycle();
        digit_l = 4'd7;
        cycle();
        cycle();
        check_eq("late_row", row_data, 8'hCE);
        cycle();

        // Reset during ROMLAT discards the fetch.
        req_l = 1; digit_l = 4'd2; row_l = 4'd3;
        cycle();
        do_reset(2);
        check_eq("mid_busy", busy, 8'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("mid_valid_l", valid_l, 8'd0);
        end

        // Random traffic with abandoned requests and back-to-back re-requests.
        for (int i = 0; i < 600; i++) begin
            if (!req_l) begin
                digit_l = 4'($urandom_range(0, 15));
                row_l   = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) req_l = 1;
            end else if ($urandom_range(0, 19) == 0) begin
                req_l = 0;
            end
            if (!req_r) begin
                digit_r = 4'($urandom_range(0, 15));
                row_r   = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) req_r = 1;
            end else if ($urandom_range(0, 19) == 0) begin
                req_r = 0;
            end
            tick();
            if (gnt_l) begin
                if ($urandom_range(0, 3) == 0) begin
                    digit_l = 4'($urandom_range(0, 15));
                    row_l   = 4'($urandom_range(0, 15));
                end else begin
                    req_l = 0;
                end
            end
            if (gnt_r) begin
                if ($urandom_range(0, 3) == 0) begin
                    digit_r = 4'($urandom_range(0, 15));
                    row_r   = 4'($urandom_range(0, 15));
                end else begin
                    req_r = 0;
                end
            end
        end
        req_l = 0; req_r = 0;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
